// File: rtl/weather_sensor_filter.sv
// rtl/weather_sensor_filter.sv - conditions raw weather samples before the severity unit
module weather_sensor_filter #(
  parameter int DEBOUNCE     = 3,
  parameter int MAX_STEP     = 10,
  parameter int REJECT_LIMIT = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       sample_valid,
  input  logic       raw_thunderstorm,
  input  logic [5:0] raw_wind,
  input  logic [1:0] raw_visibility,
  input  logic [7:0] raw_temperature,
  input  logic       fault_clr,
  output logic       thunderstorm,
  output logic [5:0] wind,
  output logic [1:0] visibility,
  output logic [7:0] temperature,
  output logic       out_valid,
  output logic       sensor_fault
);

  localparam logic [0:0] WARMUP = 1'b0;
  localparam logic [0:0] RUN    = 1'b1;

  localparam logic [2:0] DEB_LIM = 3'(DEBOUNCE);
  localparam logic [2:0] REJ_LIM = 3'(REJECT_LIMIT);
  localparam logic [8:0] STEP    = 9'(MAX_STEP);

  logic [0:0] state;
  logic [1:0] fill_cnt;
  logic [5:0] hist0, hist1, hist2;
  logic       th_q;
  logic [2:0] th_cnt;
  logic [1:0] prev_vis;
  logic [7:0] temp_q;
  logic [2:0] rej_cnt;
  logic       first_temp;

  logic [7:0] wind_sum;
  logic [5:0] wind_nxt;
  logic       th_nxt;
  logic [2:0] th_cnt_nxt;
  logic [1:0] vis_nxt;
  logic [8:0] diff;
  logic [8:0] mag;
  logic [7:0] temp_nxt;
  logic [2:0] rej_nxt;
  logic       fault_evt;
  logic       load_out;

  // Sum of the current sample and the three stored ones; max 252 fits 8 bits.
  assign wind_sum = {2'b00, raw_wind} + {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2};
  assign wind_nxt = 6'(wind_sum >> 2);
  assign vis_nxt  = (raw_visibility > prev_vis) ? raw_visibility : prev_vis;

  // Sign-extend to 9 bits so the -128/+127 extremes cannot wrap.
  assign diff = {raw_temperature[7], raw_temperature} - {temp_q[7], temp_q};
  assign mag  = diff[8] ? (~diff + 9'd1) : diff;

  assign load_out = (state == RUN) || (fill_cnt == 2'd3);

  always_comb begin
    th_nxt     = th_q;
    th_cnt_nxt = 3'd0;
    if (raw_thunderstorm != th_q) begin
      if (th_cnt + 3'd1 == DEB_LIM) th_nxt = ~th_q;
      else th_cnt_nxt = th_cnt + 3'd1;
    end
  end

  always_comb begin
    temp_nxt  = temp_q;
    rej_nxt   = rej_cnt;
    fault_evt = 1'b0;
    if (first_temp || (mag <= STEP)) begin
      temp_nxt = raw_temperature;
      rej_nxt  = 3'd0;
    end else if (rej_cnt + 3'd1 == REJ_LIM) begin
      temp_nxt  = raw_temperature;
      rej_nxt   = 3'd0;
      fault_evt = 1'b1;
    end else begin
      rej_nxt = rej_cnt + 3'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= WARMUP;
      fill_cnt     <= 2'd0;
      hist0        <= 6'd0;
      hist1        <= 6'd0;
      hist2        <= 6'd0;
      th_q         <= 1'b0;
      th_cnt       <= 3'd0;
      prev_vis     <= 2'd0;
      temp_q       <= 8'd0;
      rej_cnt      <= 3'd0;
      first_temp   <= 1'b1;
      thunderstorm <= 1'b0;
      wind         <= 6'd0;
      visibility   <= 2'd0;
      temperature  <= 8'd0;
      out_valid    <= 1'b0;
      sensor_fault <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      // A new fault event outranks a simultaneous clear.
      if (sample_valid && fault_evt) sensor_fault <= 1'b1;
      else if (fault_clr) sensor_fault <= 1'b0;

      if (sample_valid) begin
        hist2      <= hist1;
        hist1      <= hist0;
        hist0      <= raw_wind;
        th_q       <= th_nxt;
        th_cnt     <= th_cnt_nxt;
        prev_vis   <= raw_visibility;
        temp_q     <= temp_nxt;
        rej_cnt    <= rej_nxt;
        first_temp <= 1'b0;
        if (state == WARMUP) begin
          fill_cnt <= fill_cnt + 2'd1;
          if (fill_cnt == 2'd3) state <= RUN;
        end
        if (load_out) begin
          thunderstorm <= th_nxt;
          wind         <= wind_nxt;
          visibility   <= vis_nxt;
          temperature  <= temp_nxt;
          out_valid    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/weather_sensor_filter.md
Name: weather_sensor_filter

Overview:
- Upstream conditioning stage for the environmental control/severity unit.
- Accepts raw weather sensor samples and produces filtered thunderstorm, wind, visibility and temperature values, so single-sample glitches cannot push the downstream severity state machine between states.
- Filters: wind moving average, thunderstorm debounce, worst-case visibility hold, temperature glitch rejection with a sticky fault flag.

Parameters:
DEBOUNCE, 3, consecutive accepted samples of equal raw_thunderstorm needed to change the thunderstorm output (range 1..7)
MAX_STEP, 10, largest allowed |raw_temperature - temperature| for a sample to be accepted, in °C
REJECT_LIMIT, 3, consecutive rejected temperature samples that force acceptance and raise sensor_fault (range 1..7)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  reset, asynchronous, active-low
sample_valid  input  1  raw sample present this cycle; no backpressure, every asserted cycle is consumed
raw_thunderstorm  input  1  raw lightning detector
raw_wind  input  6  raw wind speed, unsigned
raw_visibility  input  2  raw visibility class, 0 = best, 3 = worst
raw_temperature  input  8  raw temperature, signed two's complement
fault_clr  input  1  clears sensor_fault
thunderstorm  output  1  debounced thunderstorm
wind  output  6  4-sample average wind
visibility  output  2  filtered visibility class
temperature  output  8  signed filtered temperature
out_valid  output  1  one-cycle pulse: outputs were updated at this edge
sensor_fault  output  1  sticky: temperature sensor produced a sustained out-of-step sequence

Behaviour:
- Reset (RST low, asynchronous): all outputs 0; wind history, debounce counter, reject counter, fill counter and previous visibility cleared; first-temperature flag set; FSM goes to WARMUP.
- Sample acceptance: a sample is taken at a rising edge with sample_valid=1. All filter state and outputs update at that same edge. out_valid=1 for exactly the following cycle, and only in RUN or on the WARMUP->RUN edge. out_valid=0 in any cycle without an accepted sample.
- FSM:
  - WARMUP: fill counter increments per accepted sample. Filters run internally, but the output registers hold 0 and out_valid stays 0. On the 4th accepted sample, go to RUN; all outputs load their filtered values and out_valid pulses.
  - RUN: every accepted sample updates the outputs and pulses out_valid. RUN is left only by reset.
- Wind: 4-entry shift history. The 8-bit unsigned sum of the 4 newest samples, shifted right by 2 (floor), drives wind. History is zero-filled at reset, so the first 4 samples fully replace the zeros before RUN.
- Thunderstorm:
  - Counter of consecutive accepted samples where raw_thunderstorm differs from the current output.
  - The counter resets to 0 whenever raw equals the output.
  - When the count reaches DEBOUNCE, the output toggles and the counter clears.
- Visibility: output = max(raw_visibility, previous accepted raw_visibility). A worse class is shown immediately and is held for one extra sample after it improves.
- Temperature:
  - The first accepted sample after reset is accepted unconditionally.
  - Otherwise, compute a 9-bit signed difference raw_temperature - temperature register.
  - |diff| <= MAX_STEP: accept, and clear the reject counter.
  - |diff| > MAX_STEP: reject (hold the value), and increment the reject counter.
  - If the reject counter reaches REJECT_LIMIT: accept the raw value, clear the counter, set sensor_fault.
  - -128 and +127 inputs must not overflow the difference.
- sensor_fault: stays high until fault_clr=1 at a rising edge.
  - If fault_clr and a new fault event occur in the same cycle, the set wins.
- Reset mid-operation: returns to WARMUP. Four new samples are required before out_valid resumes.

Test Plan:
- Warm-up and averaging: release reset, send wind 12,16,20,24 with vis 0, temp 20, no storm. No out_valid during the first 3 samples. After the 4th: wind=18, temperature=20, out_valid pulses once. Send wind 8: wind=17.
- Debounce (DEBOUNCE=3): in RUN, raw_thunderstorm 1,1,0,1,1,1. Output stays 0 until the 6th sample, then thunderstorm=1. Then raw 0,0,0: output returns to 0 on the 3rd zero.
- Temperature glitch: after acceptance of 20, send 60: temperature stays 20, sensor_fault=0. Send 21: temperature=21, reject counter cleared.
- Sustained step: after 20, send 50,50,50. Temperature stays 20 for two samples, then becomes 50 with sensor_fault=1. Pulse fault_clr: sensor_fault=0. Also check temperature -128 followed by 127 causes no overflow: the sample is rejected.
- Visibility hold: in RUN, raw vis 0,3,0,0. Output is 0,3,3,0.
- Reset mid-run: assert RST low asynchronously between clock edges during RUN. Outputs go to 0 immediately. After release, 3 samples give no out_valid; the 4th sample produces out_valid.
